// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one of four requesters access to a byte-wide UART
// transmitter, drives a start level, waits for the transmitter's busy flag to
// rise and fall, then acks the owner. A missing busy response times out with err.
// Optional feature macro: UART_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, arbitration is fixed priority with req[0] highest.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   err,
    output logic                   arb_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic                err_nxt;
    logic                arb_busy_nxt;
    logic [7:0]          tx_data_nxt;
    logic                tx_start_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0]    win_idx;

`ifdef UART_ARB_RR_EN
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    owner, owner_nxt;
    logic [IDX_W-1:0]    cand;
    logic                found;

    // Round-robin pick: first set request searching upward from the pointer.
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                win_idx = cand;
                found   = 1'b1;
            end
        end
    end
`else
    // Fixed priority pick: lowest set request index wins.
    always_comb begin
        win_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        ack_nxt      = '0;
        err_nxt      = 1'b0;
        tx_data_nxt  = tx_data;
        tx_start_nxt = tx_start;
        cnt_nxt      = cnt;
`ifdef UART_ARB_RR_EN
        ptr_nxt      = ptr;
        owner_nxt    = owner;
`endif
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt      = NUM_REQ'(1) << win_idx;
                    tx_data_nxt  = req_data[{win_idx, 3'b000} +: 8];
                    tx_start_nxt = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = GRANT;
`ifdef UART_ARB_RR_EN
                    owner_nxt    = win_idx;
`endif
                end
            end
            GRANT: begin
                if (tx_busy) begin
                    tx_start_nxt = 1'b0;
                    state_nxt    = SEND;
                end else if (cnt == CNT_LAST) begin
                    // Transmitter never answered: drop the owner, no ack.
                    tx_start_nxt = 1'b0;
                    gnt_nxt      = '0;
                    err_nxt      = 1'b1;
                    state_nxt    = IDLE;
`ifdef UART_ARB_RR_EN
                    ptr_nxt      = owner + IDX_W'(1);
`endif
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SEND: begin
                tx_start_nxt = 1'b0;
                if (!tx_busy) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                ack_nxt   = gnt;
                gnt_nxt   = '0;
                state_nxt = IDLE;
`ifdef UART_ARB_RR_EN
                ptr_nxt   = owner + IDX_W'(1);
`endif
            end
        endcase
        arb_busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            arb_busy <= 1'b0;
            tx_data  <= 8'h00;
            tx_start <= 1'b0;
            cnt      <= '0;
`ifdef UART_ARB_RR_EN
            ptr      <= '0;
            owner    <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ack      <= ack_nxt;
            err      <= err_nxt;
            arb_busy <= arb_busy_nxt;
            tx_data  <= tx_data_nxt;
            tx_start <= tx_start_nxt;
            cnt      <= cnt_nxt;
`ifdef UART_ARB_RR_EN
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-level reference model plus directed and
// randomized stimulus for uart_tx_arbiter. Honors UART_ARB_RR_EN like the DUT.
module tb_uart_tx_arbiter;

    localparam int unsigned TO = 16;
`ifdef UART_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        err;
    logic        arb_busy;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .err(err), .arb_busy(arb_busy),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model state (transaction-level).
    int        m_phase = 0;   // 0 idle, 1 awaiting busy, 2 transmitting, 3 wrap-up
    int        m_owner = 0;
    int        m_ptr = 0;
    int        m_age = 0;
    logic [3:0] e_gnt = '0;
    logic [3:0] e_ack = '0;
    logic       e_err = 1'b0;
    logic       e_arb_busy = 1'b0;
    logic [7:0] e_tx_data = '0;
    logic       e_tx_start = 1'b0;

    // Transmitter behaviour knobs.
    int  xm_lat = 2;
    int  xm_hold = 11;
    bit  xm_dead = 1'b0;
    bit  xm_rand = 1'b0;
    int  xm_wait = 0;
    int  xm_left = 0;
    logic xm_prev = 1'b0;

    bit  auto_drop = 1'b1;
    bit  rand_en = 1'b0;
    int  ack_log[$];

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // Reference model: advances one step per clock from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_ptr = 0; m_age = 0;
            e_gnt = '0; e_ack = '0; e_err = 1'b0;
            e_tx_data = '0; e_tx_start = 1'b0;
        end else begin
            e_ack = '0;
            e_err = 1'b0;
            case (m_phase)
                0: if (req != 4'b0000) begin
                    m_owner    = pick(req, m_ptr);
                    e_gnt      = 4'(1 << m_owner);
                    e_tx_data  = req_data[8*m_owner +: 8];
                    e_tx_start = 1'b1;
                    m_age      = 0;
                    m_phase    = 1;
                end
                1: begin
                    m_age++;
                    if (tx_busy) begin
                        e_tx_start = 1'b0;
                        m_phase    = 2;
                    end else if (m_age >= TO) begin
                        e_tx_start = 1'b0;
                        e_gnt      = '0;
                        e_err      = 1'b1;
                        if (RR) m_ptr = (m_owner + 1) % 4;
                        m_phase    = 0;
                    end
                end
                2: if (!tx_busy) m_phase = 3;
                default: begin
                    e_ack   = 4'(1 << m_owner);
                    e_gnt   = '0;
                    if (RR) m_ptr = (m_owner + 1) % 4;
                    m_phase = 0;
                end
            endcase
        end
        e_arb_busy = (m_phase != 0);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare, run transmitter model, update requesters.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("ack", 32'(ack), 32'(e_ack));
            chk("err", 32'(err), 32'(e_err));
            chk("arb_busy", 32'(arb_busy), 32'(e_arb_busy));
            chk("tx_data", 32'(tx_data), 32'(e_tx_data));
            chk("tx_start", 32'(tx_start), 32'(e_tx_start));
        end
        for (int i = 0; i < 4; i++) if (ack[i]) ack_log.push_back(i);

        if (reset) begin
            xm_wait = 0; xm_left = 0; tx_busy = 1'b0;
        end else if (tx_start && !xm_prev) begin
            if (xm_rand) begin
                xm_dead = ($urandom_range(0, 7) == 0);
                xm_lat  = $urandom_range(1, 5);
                xm_hold = $urandom_range(1, 12);
            end
            if (!xm_dead) xm_wait = xm_lat;
        end else if (xm_wait > 0) begin
            xm_wait--;
            if (xm_wait == 0) begin
                tx_busy = 1'b1;
                xm_left = xm_hold;
            end
        end else if (xm_left > 0) begin
            xm_left--;
            if (xm_left == 0) tx_busy = 1'b0;
        end
        xm_prev = tx_start;

        if (auto_drop) req = req & ~ack;
        if (rand_en) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 5) == 0) req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        req = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n_start, n_ack, n_err, t_rise, t_err;
        logic [3:0] last_ack;
        logic [7:0] seen_data;
        bit flag;

        reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk_en = 1'b1;
        reset = 1'b0;

        // Single request with a well-behaved transmitter.
        req_data[7:0] = 8'hA5; req = 4'b0001; xm_lat = 2; xm_hold = 11;
        n_start = 0; n_ack = 0; n_err = 0; last_ack = '0; seen_data = '0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (tx_start) begin n_start++; seen_data = tx_data; end
            if (ack != 0) begin n_ack++; last_ack = ack; end
            if (err) n_err++;
        end
        chk("single_start_cycles", 32'(n_start), 3);
        chk("single_ack_count", 32'(n_ack), 1);
        chk("single_ack_value", 32'(last_ack), 32'h1);
        chk("single_err_count", 32'(n_err), 0);
        chk("single_tx_data", 32'(seen_data), 32'hA5);

        // Contention with all four requests held.
        do_reset();
        auto_drop = 1'b0; req_data = 32'h44332211; xm_lat = 1; xm_hold = 2;
        ack_log.delete();
        req = 4'hF;
        for (int t = 0; t < 300 && ack_log.size() < 5; t++) tick();
        chk("contention_count", 32'(ack_log.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ack_log.size())
                chk($sformatf("contention_order%0d", i), 32'(ack_log[i]), RR ? 32'(i % 4) : 0);
        end
        req = '0; auto_drop = 1'b1;

        // Transmitter never answers: timeout, then retry.
        do_reset();
        xm_dead = 1'b1; req = 4'b0010;
        t_rise = -1; t_err = -1; n_ack = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (tx_start && t_rise < 0) t_rise = t;
            if (ack != 0) n_ack++;
            if (err) begin
                t_err = t;
                chk("timeout_gnt", 32'(gnt), 0);
                chk("timeout_start", 32'(tx_start), 0);
                tick();
                chk("retry_start", 32'(tx_start), 1);
                chk("retry_gnt", 32'(gnt), 32'h2);
                break;
            end
        end
        chk("timeout_latency", 32'(t_err - t_rise), 16);
        chk("timeout_no_ack", 32'(n_ack), 0);
        xm_dead = 1'b0;
        do_reset();

        // req_data changes while sending must not reach tx_data.
        xm_lat = 2; xm_hold = 6; req_data = 32'h5C00_0000; req = 4'b1000;
        flag = 1'b0; last_ack = '0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (flag && (gnt != 0 || ack != 0)) chk("data_hold", 32'(tx_data), 32'h5C);
            if (tx_busy && !flag && gnt != 0) begin req_data[31:24] = 8'hFF; flag = 1'b1; end
            if (ack != 0) last_ack = ack;
        end
        chk("data_ack", 32'(last_ack), 32'h8);

        // Reset while the byte is on the wire.
        do_reset();
        req_data = 32'h0000_0077; xm_lat = 1; xm_hold = 8; req = 4'b0001;
        for (int t = 0; t < 20 && !tx_busy; t++) tick();
        chk("rst_send_reached", 32'(tx_busy), 1);
        tick();
        req = '0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_send_gnt", 32'(gnt), 0);
        chk("rst_send_ack", 32'(ack), 0);
        chk("rst_send_err", 32'(err), 0);
        chk("rst_send_arb_busy", 32'(arb_busy), 0);
        chk("rst_send_tx_data", 32'(tx_data), 0);
        chk("rst_send_tx_start", 32'(tx_start), 0);
        n_ack = 0; n_err = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (ack != 0) n_ack++;
            if (err) n_err++;
        end
        chk("rst_send_no_ack", 32'(n_ack), 0);
        chk("rst_send_no_err", 32'(n_err), 0);
        req_data[23:16] = 8'h3C; req = 4'b0100; last_ack = '0;
        for (int t = 0; t < 40 && last_ack == 0; t++) begin
            tick();
            if (ack != 0) last_ack = ack;
        end
        chk("rst_new_ack", 32'(last_ack), 32'h4);

        // Owner drops its request mid-transaction.
        do_reset();
        req_data = 32'h009E_0000; xm_lat = 2; xm_hold = 5; req = 4'b0100;
        flag = 1'b0; n_ack = 0; last_ack = '0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (tx_busy && !flag) begin req[2] = 1'b0; flag = 1'b1; end
            if (ack != 0) begin n_ack++; last_ack = ack; end
        end
        chk("drop_ack", 32'(last_ack), 32'h4);
        chk("drop_ack_count", 32'(n_ack), 1);

        // Randomized traffic against the model.
        do_reset();
        rand_en = 1'b1; xm_rand = 1'b1;
        for (int t = 0; t < 3000; t++) tick();
        rand_en = 1'b0; xm_rand = 1'b0; xm_dead = 1'b0;
        reset = 1'b0; req = '0;
        for (int t = 0; t < 40; t++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; SHALL be fixed at 4.
REQ-002 Parameter BUSY_TIMEOUT, default 16, cycles allowed for tx_busy to rise after tx_start; SHALL be in the range 4..255.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 req  input  4  per-requester level request, held until ack or err.
REQ-006 req_data  input  32  byte for requester i at [8i+7:8i].
REQ-007 gnt  output  4  one-hot current owner; all zeros when idle.
REQ-008 ack  output  4  one-cycle pulse to the owner when its byte has finished transmitting.
REQ-009 err  output  1  one-cycle pulse on busy timeout.
REQ-010 arb_busy  output  1  high in every state except IDLE.
REQ-011 tx_data  output  8  byte to the transmitter, registered.
REQ-012 tx_start  output  1  start level to the transmitter, which detects its rising edge.
REQ-013 tx_busy  input  1  transmitter busy flag.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT, SEND, DONE, encoded in 2 bits.
REQ-015 IDLE: if any req bit is set, the winner SHALL be latched, with gnt set to one-hot winner, tx_data set to the winner's byte, tx_start set to 1, timeout counter cleared, and next state GRANT (1-cycle latency from req to tx_start).
REQ-016 GRANT: tx_start SHALL stay 1 and the counter SHALL increment each cycle; when tx_busy is 1, tx_start SHALL go to 0 and the FSM SHALL move to SEND.
REQ-017 GRANT timeout: if the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0, the block SHALL set tx_start 0, gnt 0, pulse err, advance the pointer past the owner, and go to IDLE, with no ack.
REQ-018 SEND: tx_start SHALL be 0; when tx_busy is 0, the FSM SHALL move to DONE.
REQ-019 DONE: the block SHALL pulse ack[owner] for exactly one cycle, set gnt to 0, update the pointer to owner+1 mod 4, and go to IDLE.
REQ-020 tx_data and gnt SHALL be stable from GRANT entry through DONE; req_data changes during that window SHALL be ignored.
REQ-021 Deassertion of req[owner] mid-transaction SHALL NOT abort; the transaction completes and ack still pulses.
REQ-022 Requests arriving during GRANT, SEND or DONE SHALL wait, and SHALL be arbitrated only in IDLE.
REQ-023 tx_start SHALL be 0 for at least one cycle between transactions, which IDLE/SEND/DONE guarantee.
REQ-024 At most one ack bit SHALL be high in any cycle; ack and err SHALL never coincide.
REQ-025 The timeout counter SHALL be 8 bits and saturate; its width SHALL NOT wrap before the compare.

Reset
REQ-026 On reset at a clk edge the block SHALL set state IDLE, gnt 0, ack 0, err 0, arb_busy 0, tx_data 0x00, tx_start 0, counter 0, pointer 0.
REQ-027 Reset mid-transaction SHALL discard the transaction with no ack and no err, and requesters must re-request.

Configuration
REQ-028 Macro UART_ARB_RR_EN: when defined, the winner SHALL be the first set req bit searching upward from the pointer with wrap (round-robin).
REQ-029 Without UART_ARB_RR_EN: the winner SHALL be the lowest set req index (fixed priority, req[0] highest); the pointer logic SHALL be omitted and timeout SHALL NOT alter priority.

Verification
REQ-030 Single request: req=0001, req_data[7:0]=0xA5; transmitter model raises busy 2 cycles after start and holds it 11 cycles -> tx_data=0xA5, tx_start high 3 cycles, ack=0001 one pulse, err never.
REQ-031 Contention with RR: req=1111 held, bytes 0x11/0x22/0x33/0x44 -> service order 0,1,2,3,0; without macro -> 0,0,0 repeatedly.
REQ-032 Timeout: req=0010, tx_busy tied 0 -> err pulses at cycle 16 after tx_start rises, gnt 0, no ack, retry occurs next IDLE.
REQ-033 Data change: req_data changed to 0xFF during SEND -> tx_data holds the original byte until DONE.
REQ-034 Reset in SEND: reset asserted for 1 cycle -> next cycle all outputs at reset values, no ack, no err; new req served normally.
REQ-035 Dropped request: req[2] deasserted during SEND -> ack=0100 still pulses once.
